usrt_tx_ctrl: RTL
=================

USRT_TX_CTRL -- requirements
Module: usrt_tx_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, transmit queue depth (power of two, 2..16); used only when the FIFO is compiled in.
REQ-002 i_Pclk  in  1  clock; all logic on rising edge.
REQ-003 i_Rst_n  in  1  reset; synchronous, active-low.
REQ-004 i_Tick  in  1  bit-rate enable, one-cycle pulse per bit period.
REQ-005 i_Parity  in  2  parity type: 00 none, 01 even, 10 odd, 11 none.
REQ-006 i_Data  in  8  byte to transmit.
REQ-007 i_Valid  in  1  byte present on i_Data.
REQ-008 o_Ready  out  1  queue can accept a byte; push = i_Valid & o_Ready.
REQ-009 o_Tx  out  1  serial line, idle high.
REQ-010 o_Busy  out  1  frame in progress (START through STOP).
REQ-011 o_Done  out  1  one-cycle pulse at frame end.
REQ-012 o_Level  out  5  current queue occupancy.

Function
REQ-013 Frame order on o_Tx SHALL be: start (0), D7 first down to D0, parity bit (only for 01/10), stop (1).
REQ-014 Even parity bit SHALL be XOR of the data bits; odd parity bit SHALL be its inverse.
REQ-015 Parity 00/11 SHALL produce a 10-bit frame with no parity slot.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; every transition SHALL occur only on a cycle where i_Tick=1.
REQ-017 IDLE->START on i_Tick with queue non-empty: byte popped and i_Parity latched that cycle; o_Tx=0 from the next cycle.
REQ-018 START->DATA, DATA holds 8 ticks (3-bit counter) ->PARITY or ->STOP, PARITY->STOP.
REQ-019 Each bit SHALL be held on o_Tx for exactly one tick period.
REQ-020 On the tick ending STOP: o_Done=1 for that cycle; queue non-empty -> pop and go to START (no idle gap); else -> IDLE.
REQ-021 Changes on i_Parity or i_Data during a frame SHALL NOT affect that frame.
REQ-022 o_Ready SHALL be !full; a push when full is not accepted and the byte stays on the interface.
REQ-023 Push and pop in the same cycle SHALL leave o_Level unchanged and preserve FIFO order.
REQ-024 o_Busy SHALL be 1 in START, DATA, PARITY, STOP; 0 in IDLE.

Reset
REQ-025 While i_Rst_n=0 on a clock edge: state IDLE, queue flushed, o_Tx=1, o_Busy=0, o_Done=0, o_Level=0, o_Ready=0.
REQ-026 Reset mid-frame SHALL abort the frame with o_Tx=1 from the next cycle and no o_Done pulse.
REQ-027 o_Ready SHALL rise in the first cycle after i_Rst_n returns high.

Configuration
REQ-028 Macro USRT_TX_FIFO_EN defined: queue is a FIFO of FIFO_DEPTH entries, o_Level 0..FIFO_DEPTH.
REQ-029 Macro undefined: queue is a single holding register, o_Level 0..1, FIFO_DEPTH ignored; all other behaviour identical.

Structure
REQ-030 Package usrt_pkg SHALL hold parity encodings (PAR_NONE, PAR_EVEN, PAR_ODD), the FSM state enum, data width 8, and a parity-compute function.
REQ-031 Sub-module usrt_tx_fifo SHALL implement the queue (push/pop/level/full/empty); the FSM and shifter stay in usrt_tx_ctrl.

Verification
REQ-032 Even, push 0xA5 -> o_Tx sequence 0,1,0,1,0,0,1,0,1,0,1; one o_Done at the end.
REQ-033 Odd, push 0x01 -> data 0,0,0,0,0,0,0,1, parity 0, stop 1; parity 00, push 0xFF -> 0,1x8,1 (10 bits).
REQ-034 FIFO_DEPTH=4, i_Tick held low, 5 pushes -> 4 accepted, o_Level=4, o_Ready=0; then ticks -> 4 frames back-to-back with no idle bit between them.
REQ-035 i_Rst_n low during the DATA state -> next cycle o_Tx=1, o_Level=0, o_Busy=0; no o_Done.
REQ-036 i_Parity switched from 01 to 10 during DATA -> the current frame keeps even parity and the next frame uses odd parity.
REQ-037 Without USRT_TX_FIFO_EN: second push during a frame accepted, third blocked (o_Ready=0) until the next pop.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmitter: parity encodings, FSM states, data width
// and the parity helpers.
package usrt_pkg;

   localparam int DATA_W = 8;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } usrt_state_e;

   function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic [1:0] mode);
      logic p;
      case (mode)
         PAR_EVEN: p = ^data;
         PAR_ODD:  p = ~(^data);
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

   // Encoding 11 behaves like PAR_NONE: no parity slot in the frame.
   function automatic logic parity_en(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/usrt_tx_fifo.sv
// Transmit queue for usrt_tx_ctrl. With USRT_TX_FIFO_EN defined it is a FIFO of
// FIFO_DEPTH entries; otherwise a single holding register.
module usrt_tx_fifo
   import usrt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_Pclk,
   input  logic              i_Rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [4:0]        level,
   output logic              full,
   output logic              empty
);

   if ((FIFO_DEPTH < 32'sd2) || (FIFO_DEPTH > 32'sd16) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
      $error("usrt_tx_fifo: FIFO_DEPTH must be a power of two in 2..16");
   end

`ifdef USRT_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [4:0]        cnt_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full      = (cnt_r == 5'(FIFO_DEPTH));
   assign empty     = (cnt_r == 5'd0);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rd_data   = mem_r[rd_ptr_r];
   assign level     = cnt_r;

   // Circular buffer; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= 5'd0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_r <= cnt_r + 5'd1;
            2'b01:   cnt_r <= cnt_r - 5'd1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end
`else
   logic [DATA_W-1:0] hold_r;
   logic              vld_r;

   assign full    = vld_r;
   assign empty   = ~vld_r;
   assign rd_data = hold_r;
   assign level   = {4'b0000, vld_r};

   // Single-entry holding register.
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         hold_r <= '0;
         vld_r  <= 1'b0;
      end else begin
         case ({push & ~vld_r, pop & vld_r})
            2'b10: begin
               hold_r <= wr_data;
               vld_r  <= 1'b1;
            end
            2'b01:   vld_r <= 1'b0;
            default: vld_r <= vld_r;
         endcase
      end
   end
`endif

endmodule

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit controller: queue, framing FSM and MSB-first shifter.
// Define USRT_TX_FIFO_EN for a FIFO_DEPTH-entry queue; default is one holding register.
module usrt_tx_ctrl
   import usrt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_Pclk,
   input  logic              i_Rst_n,
   input  logic              i_Tick,
   input  logic [1:0]        i_Parity,
   input  logic [DATA_W-1:0] i_Data,
   input  logic              i_Valid,
   output logic              o_Ready,
   output logic              o_Tx,
   output logic              o_Busy,
   output logic              o_Done,
   output logic [4:0]        o_Level
);

   usrt_state_e       state_r;
   usrt_state_e       state_nxt_s;
   logic              push_s;
   logic              pop_s;
   logic [DATA_W-1:0] fifo_dout_s;
   logic              full_s;
   logic              empty_s;
   logic              rdy_en_r;
   logic [DATA_W-1:0] sh_r;
   logic [DATA_W-1:0] sh_nxt_s;
   logic [2:0]        cnt_r;
   logic              par_en_r;
   logic              par_bit_r;
   logic              tx_r;
   logic              tx_nxt_s;
   logic              busy_r;
   logic              busy_nxt_s;

   assign o_Ready = rdy_en_r & ~full_s;
   assign push_s  = i_Valid & o_Ready;
   assign o_Tx    = tx_r;
   assign o_Busy  = busy_r;

   usrt_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .i_Pclk  (i_Pclk),
      .i_Rst_n (i_Rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (i_Data),
      .rd_data (fifo_dout_s),
      .level   (o_Level),
      .full    (full_s),
      .empty   (empty_s)
   );

   // FSM state register.
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; every move is gated by the bit tick. STOP chains straight into START.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      if (i_Tick) begin
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  state_nxt_s = ST_START;
                  pop_s       = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_START: state_nxt_s = ST_DATA;
            ST_DATA: begin
               if (cnt_r == 3'd7) begin
                  state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_PARITY: state_nxt_s = ST_STOP;
            ST_STOP: begin
               if (!empty_s) begin
                  state_nxt_s = ST_START;
                  pop_s       = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Outputs: line level and busy for the state being entered, plus the frame-end pulse.
   always_comb begin
      tx_nxt_s   = 1'b1;
      busy_nxt_s = 1'b1;
      sh_nxt_s   = sh_r;
      if (pop_s) begin
         sh_nxt_s = fifo_dout_s;
      end else if ((state_r == ST_DATA) && i_Tick) begin
         sh_nxt_s = {sh_r[DATA_W-2:0], 1'b0};
      end else begin
         sh_nxt_s = sh_r;
      end
      case (state_nxt_s)
         ST_IDLE: begin
            tx_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
         end
         ST_START:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = sh_nxt_s[DATA_W-1];
         ST_PARITY: tx_nxt_s = par_bit_r;
         ST_STOP:   tx_nxt_s = 1'b1;
         default: begin
            tx_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
         end
      endcase
      o_Done = i_Rst_n & i_Tick & (state_r == ST_STOP);
   end

   // Datapath registers; parity mode and bit are captured with the byte so later input changes are ignored.
   always_ff @(posedge i_Pclk) begin
      if (!i_Rst_n) begin
         rdy_en_r  <= 1'b0;
         sh_r      <= '0;
         cnt_r     <= 3'd0;
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         rdy_en_r <= 1'b1;
         sh_r     <= sh_nxt_s;
         tx_r     <= tx_nxt_s;
         busy_r   <= busy_nxt_s;
         if (pop_s) begin
            cnt_r     <= 3'd0;
            par_en_r  <= parity_en(i_Parity);
            par_bit_r <= parity_bit(fifo_dout_s, i_Parity);
         end else if ((state_r == ST_DATA) && i_Tick) begin
            cnt_r <= cnt_r + 3'd1;
         end
      end
   end

endmodule
